// File: rtl/multiplicador_ctrl.sv
// multiplicador_ctrl
//   Shift-and-add sequencing layer of the Multiplicador datapath. Computes an
//   unsigned WIDTH x WIDTH product over several cycles. An external
//   combinational Adder computes add_a + add_b. This block drives the adder
//   operands, captures the sum and runs the shift/iteration control.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      multiply request, sampled only in IDLE
//   A, B       multiplicand / multiplier, captured on the accepting edge
//   add_a      adder operand A (accumulator)
//   add_b      adder operand B (multiplicand)
//   add_saida  adder sum, carry in bit WIDTH
//   ocupado    high whenever the controller is not IDLE
//   done       one-cycle pulse while in FIM; produto is valid then
//   produto    2*WIDTH-bit result, held until the next accepted start
//
// Configuration
//   MULT_SKIP_ZERO_EN  when defined, ADD is bypassed for multiplier bits that
//                      are 0, so latency becomes WIDTH + popcount(B) cycles.

module multiplicador_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    input  logic [WIDTH:0]       add_saida,
    output logic                 ocupado,
    output logic                 done,
    output logic [2*WIDTH-1:0]   produto
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ADD   = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] FIM   = 2'd3;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] m;
    logic             c;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    cnt;

    assign add_a   = acc;
    assign add_b   = m;
    assign ocupado = (state != IDLE);
    assign done    = (state == FIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            m       <= '0;
            c       <= 1'b0;
            acc     <= '0;
            q       <= '0;
            cnt     <= '0;
            produto <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m   <= A;
                        q   <= B;
                        acc <= '0;
                        c   <= 1'b0;
                        cnt <= '0;
`ifdef MULT_SKIP_ZERO_EN
                        state <= B[0] ? ADD : SHIFT;
`else
                        state <= ADD;
`endif
                    end
                end

                ADD: begin
                    if (q[0]) begin
                        {c, acc} <= add_saida;
                    end else begin
                        c <= 1'b0;
                    end
                    state <= SHIFT;
                end

                SHIFT: begin
                    // Logical right shift of {C,ACC,Q} by one bit.
                    c   <= 1'b0;
                    acc <= {c, acc[WIDTH-1:1]};
                    q   <= {acc[0], q[WIDTH-1:1]};
                    cnt <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        // Capture the post-shift {ACC,Q} so produto is valid during FIM.
                        produto <= {c, acc, q[WIDTH-1:1]};
                        state   <= FIM;
                    end else begin
`ifdef MULT_SKIP_ZERO_EN
                        // q[1] becomes Q[0] after this shift; a 0 bit skips ADD.
                        state <= q[1] ? ADD : SHIFT;
`else
                        state <= ADD;
`endif
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplicador_ctrl.sv
// tb_multiplicador_ctrl
//   Self-checking bench for multiplicador_ctrl (WIDTH=4). Models the external
//   combinational Adder, applies a table of directed multiplies, then checks
//   start-while-busy, mid-operation reset and held results.

module tb_multiplicador_ctrl;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W:0]     add_saida;
    logic           ocupado;
    logic           done;
    logic [2*W-1:0] produto;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // External Adder model.
    assign add_saida = {1'b0, add_a} + {1'b0, add_b};

    multiplicador_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (A),
        .B         (B),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_saida (add_saida),
        .ocupado   (ocupado),
        .done      (done),
        .produto   (produto)
    );

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] prod;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int exp_latency(input logic [W-1:0] b);
`ifdef MULT_SKIP_ZERO_EN
        int ones = 0;
        for (int unsigned i = 0; i < W; i++) ones += int'(b[i]);
        return W + ones;
`else
        return 2 * W + 0 * int'(b[0]);
`endif
    endfunction

    // Accepts one multiply and checks latency, result, flags and hold.
    // With busy_start set, start stays high with A=3,B=3 until FIM has passed.
    task automatic run_mult(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2*W-1:0] prod, input bit busy_start);
        int lat;
        bit busy_ok;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk);               // accepting edge 0
        #1;
        if (busy_start) begin
            A = 4'd3; B = 4'd3;
        end else begin
            start = 1'b0;
            A = W'($urandom); B = W'($urandom);
        end
        check({name, " ocupado@0"}, 32'(ocupado), 32'd1);
        check({name, " add_b=M"}, 32'(add_b), 32'(a));
        lat = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            if (!ocupado) busy_ok = 1'b0;
        end
        if (lat == 0) begin
            mismatched++;
            compared++;
            $display("FAIL %s timeout: no done within 40 cycles", name);
            start = 1'b0;
            return;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_latency(b)));
        check({name, " ocupado busy"}, 32'(busy_ok), 32'd1);
        check({name, " produto@done"}, 32'(produto), 32'(prod));
        check({name, " ocupado@done"}, 32'(ocupado), 32'd1);
        @(posedge clk);               // FIM -> IDLE, start here must be ignored
        #1;
        start = 1'b0;
        check({name, " done pulse"}, 32'(done), 32'd0);
        check({name, " idle after"}, 32'(ocupado), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check({name, " produto hold"}, 32'(produto), 32'(prod));
    endtask

    initial begin
        vecs[0] = '{a: 4'd10, b: 4'd5,  prod: 8'h32};
        vecs[1] = '{a: 4'd15, b: 4'd15, prod: 8'hE1};
        vecs[2] = '{a: 4'd9,  b: 4'd0,  prod: 8'h00};
        vecs[3] = '{a: 4'd0,  b: 4'd9,  prod: 8'h00};
        vecs[4] = '{a: 4'd1,  b: 4'd1,  prod: 8'h01};
        vecs[5] = '{a: 4'd15, b: 4'd1,  prod: 8'h0F};
        vecs[6] = '{a: 4'd5,  b: 4'd15, prod: 8'h4B};

        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset done",    32'(done),    32'd0);
        check("reset ocupado", 32'(ocupado), 32'd0);
        check("reset produto", 32'(produto), 32'd0);
        check("reset add_a",   32'(add_a),   32'd0);
        check("reset add_b",   32'(add_b),   32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_mult($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod, 1'b0);
        end

        // start held high with other operands during ADD, SHIFT and FIM.
        run_mult("busy8x6", 4'd8, 4'd6, 8'd48, 1'b1);
        run_mult("next3x3", 4'd3, 4'd3, 8'd9, 1'b0);

        // Mid-operation asynchronous reset.
        @(negedge clk);
        A = 4'd7; B = 4'd7; start = 1'b1;
        @(posedge clk);               // edge 0
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);    // edges 1, 2
        #3;
        rst = 1'b1;
        #1;
        check("abort done",    32'(done),    32'd0);
        check("abort ocupado", 32'(ocupado), 32'd0);
        check("abort produto", 32'(produto), 32'd0);
        check("abort add_a",   32'(add_a),   32'd0);
        check("abort add_b",   32'(add_b),   32'd0);
        @(posedge clk);               // edge 3 under reset
        @(negedge clk);
        rst = 1'b0;
        begin
            bit saw_done = 1'b0;
            for (int k = 0; k < 2 * W + 4; k++) begin
                @(posedge clk);
                #1;
                if (done || ocupado) saw_done = 1'b1;
            end
            check("abort no done", 32'(saw_done), 32'd0);
        end
        run_mult("fresh7x7", 4'd7, 4'd7, 8'd49, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multiplicador_ctrl.md
# multiplicador_ctrl

Sequential shift-and-add multiplier controller. It computes an unsigned WIDTH×WIDTH product over several cycles by sequencing the team's combinational `Adder` (WIDTH-bit operands, WIDTH+1-bit `saida`), which sits outside this block. The block drives the adder operands, captures its result and runs the shift/iteration control. It is the sequencing layer of the Multiplicador datapath and exposes a start/done handshake to the core.

## Interface
- `WIDTH`, default 4: operand width. Legal range is WIDTH ≥ 2. The product is 2·WIDTH bits.
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a multiply. Sampled only in IDLE.
- `A` input WIDTH: multiplicand. Captured on the accepting edge.
- `B` input WIDTH: multiplier. Captured on the accepting edge.
- `add_a` output WIDTH: adder operand A. Driven from the accumulator register.
- `add_b` output WIDTH: adder operand B. Driven from the multiplicand register.
- `add_saida` input WIDTH+1: adder sum from the external `Adder`, with carry in bit WIDTH.
- `ocupado` output 1: high whenever state ≠ IDLE.
- `done` output 1: one-cycle pulse, high only in state FIM.
- `produto` output 2·WIDTH: result. Holds its value until the next accepted start.

## Operation
- Registers:
  - M (WIDTH): multiplicand.
  - C (1): carry.
  - ACC (WIDTH): accumulator.
  - Q (WIDTH): multiplier / low product bits.
  - cnt: counts 0..WIDTH.
  - state.
- States: IDLE, ADD, SHIFT, FIM.
- IDLE:
  - If start=1: load M←A, Q←B, ACC←0, C←0, cnt←0, then go to ADD.
  - Otherwise stay in IDLE.
- ADD:
  - If Q[0]=1: {C,ACC}←add_saida.
  - If Q[0]=0: ACC is unchanged and C←0.
  - Next state is SHIFT.
- SHIFT:
  - {C,ACC,Q}←{1'b0,C,ACC,Q}>>1, i.e. a logical right shift of the 2·WIDTH+1-bit vector.
  - cnt←cnt+1.
  - If cnt+1=WIDTH go to FIM, else go to ADD.
- FIM:
  - produto←{ACC,Q} is registered on entry to FIM, so it is valid while done=1.
  - Next state is IDLE.
- add_a=ACC and add_b=M at all times. The adder is purely combinational, so its result is used in the same cycle.
- Arithmetic is unsigned. No overflow is possible: (2^WIDTH−1)² < 2^(2·WIDTH).
- start while ocupado=1 (ADD, SHIFT or FIM) is ignored. It is not queued.
- A and B may change freely after the accepting edge without affecting the result.
- Reset values: state=IDLE, all registers 0, produto=0, done=0, ocupado=0, add_a=0, add_b=0.
- rst asserted mid-operation aborts immediately to IDLE with all of the above cleared. No done pulse is produced for the aborted operation.

## Timing
- The accepting edge is edge 0 (start=1 in IDLE).
- The state sequence is ADD/SHIFT pairs on edges 1..2·WIDTH. FIM is entered at edge 2·WIDTH.
- done is high for exactly one cycle, from edge 2·WIDTH to edge 2·WIDTH+1. With WIDTH=4 that is edge 8.
- ocupado is high from edge 0 to edge 2·WIDTH+1.
- The earliest next accept is edge 2·WIDTH+2, when start is sampled in IDLE.
- Fixed latency is independent of operand values unless the configuration macro below is defined.
- Back-to-back throughput is one product per 2·WIDTH+2 cycles.

## Configuration
- Macro `MULT_SKIP_ZERO_EN`.
- Undefined (default): behaviour and timing exactly as above.
- Defined: when the bit being processed has Q[0]=0, the ADD state is bypassed.
  - IDLE and SHIFT go directly to SHIFT instead of ADD, based on the current Q[0].
  - A 0 bit costs 1 cycle; a 1 bit costs 2 cycles.
  - done rises at edge WIDTH+popcount(B).
  - Results are identical to the default build.

## Test plan
- A=10, B=5 (WIDTH=4), start pulsed for one cycle → done at edge 8 after accept, produto=50 (8'h32). produto holds until the next start.
- A=15, B=15 → produto=225 (8'hE1). Exercises the carry path, with add_saida[4]=1 on intermediate additions.
- A=9, B=0 and A=0, B=9 → produto=0 in both cases. done still arrives at edge 8.
- A=8, B=6 accepted. start re-asserted with A=3, B=3 during ADD, SHIFT and FIM → ignored; produto=48. A following start in IDLE gives produto=9.
- Mid-operation reset: A=7, B=7, rst pulsed at edge 3 → done=0, ocupado=0, produto=0 immediately. No done pulse follows. A fresh A=7, B=7 gives produto=49.
- With `MULT_SKIP_ZERO_EN` defined: A=8, B=6 → done at edge 6, produto=48. A=5, B=15 → done at edge 8, produto=75.
